// File: rtl/ps2_device_tx_if.sv
// Host-side bus of the PS/2 device transmitter.
// Ports: wr/din/clear in; level/empty/full/overflow/busy out.
interface ps2_device_tx_if #(
  parameter int FIFO_BITS = 3
);
  logic                 wr;
  logic [7:0]           din;
  logic                 clear;
  logic [FIFO_BITS:0]   level;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 busy;

  modport master (
    output wr, din, clear,
    input  level, empty, full, overflow, busy
  );

  modport slave (
    input  wr, din, clear,
    output level, empty, full, overflow, busy
  );
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: byte FIFO, clock divider, frame FSM.
// Ports: clk_sys, reset_n, bus (slave), ps2_clk_in in; ps2_clk, ps2_data out.
module ps2_device_tx #(
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100,
  parameter int GAP       = 2
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  ps2_device_tx_if.slave bus,
  input  logic           ps2_clk_in,
  output logic           ps2_clk,
  output logic           ps2_data
);
  localparam int DEPTH = 2 ** FIFO_BITS;
  localparam int DW = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
  localparam int GW = $clog2(GAP + 2);
  localparam logic [DW-1:0] DIV_MAX = DW'(PS2DIV);
  localparam logic [FIFO_BITS:0] FULL_LVL = (FIFO_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t               r_state;
  logic [DW-1:0]        r_div;
  logic                 r_clk_ps2;
  logic [1:0]           r_sync;
  logic [9:0]           r_frame;
  logic [3:0]           r_bitidx;
  logic [GW-1:0]        r_gapcnt;
  logic [FIFO_BITS:0]   r_wptr;
  logic [FIFO_BITS:0]   r_rptr;
  logic                 r_ovf;
  logic                 r_data;
  logic [7:0]           r_mem [DEPTH];

  logic                 w_tick;
  logic [FIFO_BITS:0]   w_level;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_ps2_clk;
  logic                 w_inhibit;
  logic                 w_push;
  logic                 w_gap_done;
  logic [7:0]           w_head;

  // tick marks the edge where clk_ps2 rises
  assign w_tick     = (r_div == DIV_MAX) && !r_clk_ps2;
  assign w_level    = r_wptr - r_rptr;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == FULL_LVL);
  assign w_ps2_clk  = (r_state == S_SEND) ? r_clk_ps2 : 1'b1;
  // host pulls the line low while we release it
  assign w_inhibit  = !r_sync[1] && w_ps2_clk;
  assign w_push     = bus.wr && !w_full && !bus.clear;
  assign w_gap_done = (int'(r_gapcnt) + 1) >= GAP;
  assign w_head     = r_mem[r_rptr[FIFO_BITS-1:0]];

  assign ps2_clk      = w_ps2_clk;
  assign ps2_data     = r_data;
  assign bus.level    = w_level;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_ovf;
  assign bus.busy     = (r_state != S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_clk_ps2 <= 1'b0;
      r_sync    <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ps2_clk_in};
      if (r_div == DIV_MAX) begin
        r_div     <= '0;
        r_clk_ps2 <= !r_clk_ps2;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_BITS-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || bus.clear) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovf    <= 1'b0;
      r_data   <= 1'b1;
      r_bitidx <= '0;
      r_gapcnt <= '0;
      r_frame  <= '0;
    end else begin
      // a pop this cycle never makes room for this write
      if (bus.wr) begin
        if (w_full) r_ovf <= 1'b1;
        else r_wptr <= r_wptr + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_tick && !w_empty && !w_inhibit) begin
            r_frame  <= {1'b1, ~^w_head, w_head};
            r_data   <= 1'b0;
            r_bitidx <= '0;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_inhibit) begin
            // abort without pop; byte is resent later
            r_data   <= 1'b1;
            r_gapcnt <= '0;
            r_state  <= S_GAP;
          end else if (w_tick) begin
            if (r_bitidx == 4'd10) begin
              r_rptr   <= r_rptr + 1'b1;
              r_data   <= 1'b1;
              r_gapcnt <= '0;
              r_state  <= S_GAP;
            end else begin
              r_data   <= r_frame[r_bitidx];
              r_bitidx <= r_bitidx + 4'd1;
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (w_gap_done) begin
              if (!w_inhibit) r_state <= S_IDLE;
            end else begin
              r_gapcnt <= r_gapcnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
